// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, bank selects and pooling FSM states for the CONV accelerator
package cnn_pkg;
    localparam int DATA_W = 20;
    localparam int IMG_W  = 64;
    localparam int ADDR_W = 12;
    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;
    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, CAP, WR, FIN} pool_state_t;
endpackage

// File: rtl/maxpool_2x2_engine_if.sv
// maxpool_2x2_engine_if: control and shared L0/L1 memory port of the pooling engine
//   start/busy/done: pass control; crd/caddr_rd/cdata_rd: L0 read port
//   cwr/caddr_wr/cdata_wr: L1 write port; csel: bank select shared by both
//   master = engine side, slave = controller/memory side
interface maxpool_2x2_engine_if;
    import cnn_pkg::*;
    logic              start, busy, done, crd, cwr;
    logic [ADDR_W-1:0] caddr_rd, caddr_wr;
    logic [DATA_W-1:0] cdata_rd, cdata_wr;
    logic [2:0]        csel;
    modport master (input start, cdata_rd,
                    output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel);
    modport slave  (output start, cdata_rd,
                    input busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel);
endinterface

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: 2x2 window counters plus L0 read and L1 write address formation
//   clr: zero counters; adv: step to next window (raster, c fastest)
//   k: window position 0..3 -> rd_addr; wr_addr = {00,r,c}
//   last_window: high after stepping off window (31,31), i.e. during its write
module pool_addr_gen
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              adv,
    input  logic [1:0]        k,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last_window
);
    logic [4:0] r, c;
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r           <= '0;
            c           <= '0;
            last_window <= 1'b0;
        end else if (adv) begin
            {r, c}      <= {r, c} + 10'd1;
            last_window <= &{r, c};
        end
    end
    assign rd_addr = {r, 1'b0, c, 1'b0} + (k[1] ? ADDR_W'(IMG_W) : '0) + ADDR_W'(k[0]);
    assign wr_addr = {2'b00, r, c};
endmodule

// File: rtl/maxpool_2x2_engine.sv
// maxpool_2x2_engine: 2x2 stride-2 max pooling from the L0 buffer into the L1 buffer
//   clk, reset (sync, active-high); bus: maxpool_2x2_engine_if.master
//   (start/busy/done control, crd/caddr_rd/cdata_rd read, cwr/caddr_wr/cdata_wr write, csel)
module maxpool_2x2_engine
    import cnn_pkg::*;
#(
    parameter logic [2:0] CSEL_SRC = CSEL_L0,
    parameter logic [2:0] CSEL_DST = CSEL_L1
)(
    input logic                  clk,
    input logic                  reset,
    maxpool_2x2_engine_if.master bus
);
    pool_state_t       state, nxt;
    logic [DATA_W-1:0] max_q, max_nxt;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic              last_window, nxt_rd, nxt_wr;
    logic [1:0]        k;

    pool_addr_gen u_addr (
        .clk(clk), .reset(reset), .clr(state == IDLE), .adv(state == CAP),
        .k(k), .rd_addr(rd_addr), .wr_addr(wr_addr), .last_window(last_window)
    );

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = bus.start ? RD0 : IDLE;
            RD0:     nxt = RD1;
            RD1:     nxt = RD2;
            RD2:     nxt = RD3;
            RD3:     nxt = CAP;
            CAP:     nxt = WR;
            WR:      nxt = last_window ? FIN : RD0;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so strobes line up with the state they name.
    assign nxt_rd  = nxt inside {RD0, RD1, RD2, RD3};
    assign nxt_wr  = nxt == WR;
    assign k       = {nxt == RD2 || nxt == RD3, nxt == RD1 || nxt == RD3};
    // Read data trails its strobe by one state; the RD3 sample arrives in CAP and
    // is folded in while forming the write value.
    assign max_nxt = (bus.cdata_rd > max_q) ? bus.cdata_rd : max_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            max_q        <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.crd      <= 1'b0;
            bus.cwr      <= 1'b0;
            bus.caddr_rd <= '0;
            bus.caddr_wr <= '0;
            bus.cdata_wr <= '0;
            bus.csel     <= '0;
        end else begin
            state <= nxt;
            if (state == RD1)
                max_q <= bus.cdata_rd;
            else if (state inside {RD2, RD3, CAP})
                max_q <= max_nxt;
            bus.busy <= !(nxt inside {IDLE, FIN});
            bus.done <= nxt == FIN;
            bus.crd  <= nxt_rd;
            bus.cwr  <= nxt_wr;
            if (nxt_rd) begin
                bus.caddr_rd <= rd_addr;
                bus.csel     <= CSEL_SRC;
            end
            if (nxt_wr) begin
                bus.caddr_wr <= wr_addr;
                bus.cdata_wr <= max_nxt;
                bus.csel     <= CSEL_DST;
            end
        end
    end
endmodule
